// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer that feeds the shared ALU and returns its result.
// Optional: define ALU_ARB_OPCNT_EN to add op_cnt, saturating per-requester counts of completed responses.
module alu_req_arbiter #(
    parameter int DATA_W  = 3,
    parameter int SEL_W   = 2,
    parameter int RES_W   = 6,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*SEL_W-1:0]  req_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [RES_W-1:0]    alu_result,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [RES_W-1:0]    rsp_data,
`ifdef ALU_ARB_OPCNT_EN
    output logic [15:0]         op_cnt,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       winner;

    generate
        if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
            $error("alu_req_arbiter: ALU_LAT=%0d is outside 1..15", ALU_LAT);
        end
    endgenerate

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Under contention the requester that did not win last time gets the grant
    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        winner     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    winner = ~last_grant;
                end else begin
                    winner = req_valid[1];
                end
                if (req_valid != 2'b00) begin
                    req_ready  = winner ? 2'b10 : 2'b01;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cnt == LAST_CNT) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // last_grant doubles as the owner of the in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        alu_a      <= winner ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                        alu_b      <= winner ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                        alu_sel    <= winner ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
                        last_grant <= winner;
                        cnt        <= '0;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        rsp_data <= alu_result;
                        rsp_id   <= last_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt <= '0;
        end else if (state == RESP) begin
            if (rsp_id) begin
                if (op_cnt[15:8] != 8'hFF) begin
                    op_cnt[15:8] <= op_cnt[15:8] + 8'd1;
                end
            end else if (op_cnt[7:0] != 8'hFF) begin
                op_cnt[7:0] <= op_cnt[7:0] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: vector table plus hand sequences, responses checked via a queue.
// Builds the op_cnt saturation test when ALU_ARB_OPCNT_EN is defined.
module tb_alu_req_arbiter;

    typedef struct packed {
        logic [1:0] valid;
        logic [2:0] a0;
        logic [2:0] b0;
        logic [1:0] sel0;
        logic [2:0] a1;
        logic [2:0] b1;
        logic [1:0] sel1;
        logic [1:0] exp_ready;
        logic       exp_id;
        logic [5:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic       id;
        logic [5:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_a;
    logic [5:0] req_b;
    logic [3:0] req_sel;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;
    logic       rsp_valid;
    logic       rsp_id;
    logic [5:0] rsp_data;
    logic       busy;
`ifdef ALU_ARB_OPCNT_EN
    logic [15:0] op_cnt;
`endif

    logic [1:0] req_valid3;
    logic [1:0] req_ready3;
    logic [5:0] req_a3;
    logic [5:0] req_b3;
    logic [3:0] req_sel3;
    logic [2:0] alu_a3;
    logic [2:0] alu_b3;
    logic [1:0] alu_sel3;
    logic [5:0] alu_result3;
    logic       rsp_valid3;
    logic       rsp_id3;
    logic [5:0] rsp_data3;
    logic       busy3;
`ifdef ALU_ARB_OPCNT_EN
    logic [15:0] op_cnt3;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t sb_head;
    vec_t vecs[10];

    function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
        case (sel)
            2'd0:    return {3'b000, a} + {3'b000, b};
            2'd1:    return {3'b000, a} - {3'b000, b};
            2'd2:    return {3'b000, a & b};
            default: return {3'b000, a | b};
        endcase
    endfunction

    assign alu_result  = alu_model(alu_a, alu_b, alu_sel);
    assign alu_result3 = alu_model(alu_a3, alu_b3, alu_sel3);

    alu_req_arbiter #(.ALU_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef ALU_ARB_OPCNT_EN
        .op_cnt     (op_cnt),
`endif
        .busy       (busy)
    );

    alu_req_arbiter #(.ALU_LAT(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_a      (req_a3),
        .req_b      (req_b3),
        .req_sel    (req_sel3),
        .alu_a      (alu_a3),
        .alu_b      (alu_b3),
        .alu_sel    (alu_sel3),
        .alu_result (alu_result3),
        .rsp_valid  (rsp_valid3),
        .rsp_id     (rsp_id3),
        .rsp_data   (rsp_data3),
`ifdef ALU_ARB_OPCNT_EN
        .op_cnt     (op_cnt3),
`endif
        .busy       (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_ops(input logic [2:0] a0, input logic [2:0] b0, input logic [1:0] sel0,
                           input logic [2:0] a1, input logic [2:0] b1, input logic [1:0] sel1);
        req_a   = {a1, a0};
        req_b   = {b1, b0};
        req_sel = {sel1, sel0};
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 50);
        checkOutput("idle_reached", int'(busy), 0);
    endtask

    // Every response from the ALU_LAT=1 instance must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_rsp: got rsp_id=%0d rsp_data=%0d, expected no response", rsp_id, rsp_data);
            end else begin
                sb_head = sb.pop_front();
                checkOutput("rsp_id", int'(rsp_id), int'(sb_head.id));
                checkOutput("rsp_data", int'(rsp_data), int'(sb_head.data));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req_valid = v.valid;
        set_ops(v.a0, v.b0, v.sel0, v.a1, v.b1, v.sel1);
        #1;
        checkOutput("req_ready", int'(req_ready), int'(v.exp_ready));
        if (v.exp_ready != 2'b00) begin
            sb.push_back({v.exp_id, v.exp_data});
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            wait_idle();
        end
    endtask

    initial begin
        int grants;
        int cyc;
        int last_rsp;

        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_valid3 = 2'b00;
        set_ops(3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0);
        req_a3 = '0;
        req_b3 = '0;
        req_sel3 = '0;

        vecs[0] = '{2'b11, 3'd3, 3'd5, 2'd0, 3'd1, 3'd2, 2'd1, 2'b01, 1'b0, 6'd8};
        vecs[1] = '{2'b11, 3'd3, 3'd5, 2'd0, 3'd1, 3'd2, 2'd1, 2'b10, 1'b1, 6'd63};
        vecs[2] = '{2'b10, 3'd0, 3'd0, 2'd0, 3'd7, 3'd7, 2'd3, 2'b10, 1'b1, 6'd7};
        vecs[3] = '{2'b10, 3'd0, 3'd0, 2'd0, 3'd6, 3'd3, 2'd2, 2'b10, 1'b1, 6'd2};
        vecs[4] = '{2'b01, 3'd3, 3'd5, 2'd1, 3'd0, 3'd0, 2'd0, 2'b01, 1'b0, 6'd62};
        vecs[5] = '{2'b01, 3'd7, 3'd7, 2'd0, 3'd0, 3'd0, 2'd0, 2'b01, 1'b0, 6'd14};
        vecs[6] = '{2'b11, 3'd5, 3'd2, 2'd3, 3'd4, 3'd6, 2'd2, 2'b10, 1'b1, 6'd4};
        vecs[7] = '{2'b00, 3'd5, 3'd2, 2'd3, 3'd4, 3'd6, 2'd2, 2'b00, 1'b0, 6'd0};
        vecs[8] = '{2'b11, 3'd5, 3'd2, 2'd3, 3'd4, 3'd6, 2'd2, 2'b01, 1'b0, 6'd7};
        vecs[9] = '{2'b11, 3'd0, 3'd0, 2'd1, 3'd7, 3'd1, 2'd0, 2'b10, 1'b1, 6'd8};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", int'(req_ready), 0);
        checkOutput("rst_alu_a", int'(alu_a), 0);
        checkOutput("rst_alu_b", int'(alu_b), 0);
        checkOutput("rst_alu_sel", int'(alu_sel), 0);
        checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
        checkOutput("rst_rsp_id", int'(rsp_id), 0);
        checkOutput("rst_rsp_data", int'(rsp_data), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_busy3", int'(busy3), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        checkOutput("hold_alu_a", int'(alu_a), 7);
        checkOutput("hold_alu_b", int'(alu_b), 1);
        checkOutput("hold_alu_sel", int'(alu_sel), 0);

        // Single op cycle by cycle: busy for two cycles, response in the second
        @(negedge clk);
        req_valid = 2'b01;
        set_ops(3'd3, 3'd5, 2'd0, 3'd0, 3'd0, 2'd0);
        #1;
        checkOutput("lat_ready", int'(req_ready), 1);
        sb.push_back({1'b0, 6'd8});
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checkOutput("lat_c1_busy", int'(busy), 1);
        checkOutput("lat_c1_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        #1;
        checkOutput("lat_c2_busy", int'(busy), 1);
        checkOutput("lat_c2_rsp", int'(rsp_valid), 1);
        @(negedge clk);
        #1;
        checkOutput("lat_c3_busy", int'(busy), 0);
        checkOutput("lat_c3_rsp", int'(rsp_valid), 0);

        // Request raised during EXEC waits and is granted once back in IDLE
        @(negedge clk);
        req_valid = 2'b01;
        set_ops(3'd1, 3'd2, 2'd0, 3'd4, 3'd4, 2'd0);
        #1;
        checkOutput("wait_ready0", int'(req_ready), 1);
        sb.push_back({1'b0, 6'd3});
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checkOutput("wait_ready_exec", int'(req_ready), 0);
        @(negedge clk);
        #1;
        checkOutput("wait_ready_resp", int'(req_ready), 0);
        @(negedge clk);
        #1;
        checkOutput("wait_ready1", int'(req_ready), 2);
        sb.push_back({1'b1, 6'd8});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Request withdrawn before its handshake leaves nothing behind
        @(negedge clk);
        req_valid = 2'b01;
        set_ops(3'd2, 3'd1, 2'd1, 3'd6, 3'd5, 2'd3);
        #1;
        checkOutput("drop_ready", int'(req_ready), 1);
        sb.push_back({1'b0, 6'd1});
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("drop_alu_a", int'(alu_a), 2);
        checkOutput("drop_alu_sel", int'(alu_sel), 1);
        checkOutput("drop_busy", int'(busy), 0);

        // Reset while in EXEC drops the operation
        @(negedge clk);
        req_valid = 2'b10;
        set_ops(3'd0, 3'd0, 2'd0, 3'd3, 3'd3, 2'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checkOutput("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", int'(busy), 0);
        checkOutput("mid_rsp_valid", int'(rsp_valid), 0);
        checkOutput("mid_alu_a", int'(alu_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("mid_no_rsp", int'(rsp_valid), 0);
        end

        // Continuous contention straight after reset: grants 0,1,0,1 spaced three cycles
        @(negedge clk);
        req_valid = 2'b11;
        set_ops(3'd2, 3'd3, 2'd0, 3'd5, 3'd1, 2'd1);
        grants = 0;
        cyc = 0;
        last_rsp = -1;
        while (cyc < 60 && (grants < 4 || busy)) begin
            #1;
            checkOutput("cont_not_both", int'(req_ready == 2'b11), 0);
            if (grants < 4 && req_ready != 2'b00) begin
                checkOutput("cont_grant", int'(req_ready), (grants % 2 == 0) ? 1 : 2);
                if (grants % 2 == 0) begin
                    sb.push_back({1'b0, 6'd5});
                end else begin
                    sb.push_back({1'b1, 6'd4});
                end
                grants++;
            end
            if (rsp_valid) begin
                if (last_rsp >= 0) begin
                    checkOutput("cont_spacing", cyc - last_rsp, 3);
                end
                last_rsp = cyc;
            end
            @(negedge clk);
            cyc++;
            if (grants == 4) begin
                req_valid = 2'b00;
            end
        end
        checkOutput("cont_grants", grants, 4);
        wait_idle();

        // ALU_LAT=3 instance: operands held three cycles, response four cycles after handshake
        @(negedge clk);
        req_valid3 = 2'b10;
        req_a3 = {3'd7, 3'd0};
        req_b3 = {3'd7, 3'd0};
        req_sel3 = {2'd3, 2'd0};
        #1;
        checkOutput("lat3_ready", int'(req_ready3), 2);
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            req_valid3 = 2'b00;
            #1;
            if (i <= 3) begin
                checkOutput("lat3_alu_a", int'(alu_a3), 7);
                checkOutput("lat3_alu_b", int'(alu_b3), 7);
                checkOutput("lat3_alu_sel", int'(alu_sel3), 3);
                checkOutput("lat3_no_rsp", int'(rsp_valid3), 0);
            end else if (i == 4) begin
                checkOutput("lat3_rsp_valid", int'(rsp_valid3), 1);
                checkOutput("lat3_rsp_id", int'(rsp_id3), 1);
                checkOutput("lat3_rsp_data", int'(rsp_data3), 7);
            end else begin
                checkOutput("lat3_rsp_done", int'(rsp_valid3), 0);
            end
        end

`ifdef ALU_ARB_OPCNT_EN
        // 300 back-to-back ops from requester 0 saturate its counter
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("opcnt_rst", int'(op_cnt), 0);
        req_valid = 2'b01;
        set_ops(3'd1, 3'd1, 2'd0, 3'd0, 3'd0, 2'd0);
        grants = 0;
        cyc = 0;
        while (cyc < 2000 && (grants < 300 || busy)) begin
            if (grants < 300 && req_ready == 2'b01) begin
                sb.push_back({1'b0, 6'd2});
                grants++;
            end
            @(negedge clk);
            #1;
            cyc++;
            if (grants == 300) begin
                req_valid = 2'b00;
            end
        end
        checkOutput("opcnt_grants", grants, 300);
        checkOutput("opcnt_req0", int'(op_cnt[7:0]), 255);
        checkOutput("opcnt_req1", int'(op_cnt[15:8]), 0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
